// File: rtl/cmp16_operand_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : cmp16_operand_loader_if
// Description : Bundles every non-clock/reset signal of the 16-bit comparator
//               operand loader.
//               - Nibble stream: in_valid / in_ready / in_nibble, plus in_par
//                 when CMP16_LOADER_PARITY_EN is defined.
//               - Operand pair: op_valid / op_ready / op_a / op_b and the
//                 cascade inputs cas_gt / cas_le / cas_eq.
//               - Comparator result inputs: cmp_gt / cmp_le / cmp_eq.
//               - Registered result: res_valid / res_gt / res_le / res_eq,
//                 plus the sticky protocol error err.
//               The master modport is the loader's view and the slave modport
//               is the view of the environment around it.
// Macro       : CMP16_LOADER_PARITY_EN adds the in_par signal.
// Revision    : 1.0 - initial release
// ============================================================================
interface cmp16_operand_loader_if;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_nibble;
`ifdef CMP16_LOADER_PARITY_EN
    logic        in_par;
`endif
    logic        op_valid;
    logic        op_ready;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        cas_gt;
    logic        cas_le;
    logic        cas_eq;
    logic        cmp_gt;
    logic        cmp_le;
    logic        cmp_eq;
    logic        res_valid;
    logic        res_gt;
    logic        res_le;
    logic        res_eq;
    logic        err;

    modport master (
`ifdef CMP16_LOADER_PARITY_EN
        input  in_par,
`endif
        input  in_valid, in_nibble, op_ready, cmp_gt, cmp_le, cmp_eq,
        output in_ready, op_valid, op_a, op_b, cas_gt, cas_le, cas_eq,
        output res_valid, res_gt, res_le, res_eq, err
    );

    modport slave (
`ifdef CMP16_LOADER_PARITY_EN
        output in_par,
`endif
        output in_valid, in_nibble, op_ready, cmp_gt, cmp_le, cmp_eq,
        input  in_ready, op_valid, op_a, op_b, cas_gt, cas_le, cas_eq,
        input  res_valid, res_gt, res_le, res_eq, err
    );
endinterface
`default_nettype wire

// File: rtl/cmp16_operand_loader.sv
`default_nettype none
// ============================================================================
// Module      : cmp16_operand_loader
// Description : Upstream feeder for the 16-bit cascaded magnitude comparator.
//               - Assembles operand A and then operand B from a 4-bit nibble
//                 stream, one nibble per handshake.
//               - Presents the pair and the cascade inputs until the consumer
//                 takes them.
//               - Captures the comparator's GT/LE/EQ result into a registered
//                 single-cycle pulse.
// Parameters  : MSB_FIRST   - 0: nibble [3:0] arrives first,
//                             1: nibble [15:12] arrives first.
//               CAS_DEFAULT - {cas_gt, cas_le, cas_eq} driven while presenting.
// Ports       : clk - clock, rising edge.
//               rst - synchronous reset, active-high.
//               bus - cmp16_operand_loader_if.master, which carries the nibble
//                     stream, the operand pair and cascade inputs, the
//                     comparator result inputs, the registered result and err.
// Macro       : CMP16_LOADER_PARITY_EN - when defined, each nibble carries
//               in_par, chosen so that in_par together with in_nibble holds an
//               odd number of ones. A mismatch sets the sticky err flag and
//               drops the frame. When undefined, err is tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module cmp16_operand_loader #(
    parameter bit         MSB_FIRST   = 1'b0,
    parameter logic [2:0] CAS_DEFAULT = 3'b001
) (
    input  wire logic             clk,
    input  wire logic             rst,
    cmp16_operand_loader_if.master bus
);

    typedef enum logic [1:0] {
        ST_LOAD_A  = 2'd0,
        ST_LOAD_B  = 2'd1,
        ST_PRESENT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [15:0] op_a_q, op_a_d;
    logic [15:0] op_b_q, op_b_d;
    logic        res_valid_q, res_valid_d;
    logic [2:0]  res_q, res_d;      // {gt, le, eq}
    logic        err_q, err_d;

    logic        w_accept;
    logic        w_par_ok;
    logic [1:0]  w_slot;

    assign w_accept = bus.in_valid && (state_q != ST_PRESENT);
    assign w_slot   = MSB_FIRST ? (2'd3 - cnt_q) : cnt_q;

`ifdef CMP16_LOADER_PARITY_EN
    // in_par must make the total number of ones (nibble plus in_par) odd.
    assign w_par_ok = (bus.in_par == ~(^bus.in_nibble));
`else
    assign w_par_ok = 1'b1;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        res_valid_d = 1'b0;
        res_d       = res_q;
        err_d       = err_q;

        case (state_q)
            ST_LOAD_A, ST_LOAD_B: begin
                if (w_accept) begin
                    if (!w_par_ok) begin
                        // A corrupt nibble poisons the whole frame: restart at A.
                        err_d   = 1'b1;
                        cnt_d   = 2'd0;
                        state_d = ST_LOAD_A;
                    end else begin
                        if (state_q == ST_LOAD_A) begin
                            op_a_d[{w_slot, 2'b00} +: 4] = bus.in_nibble;
                        end else begin
                            op_b_d[{w_slot, 2'b00} +: 4] = bus.in_nibble;
                        end
                        cnt_d = cnt_q + 2'd1;   // wraps to 0 after the 4th nibble
                        if (cnt_q == 2'd3) begin
                            state_d = (state_q == ST_LOAD_A) ? ST_LOAD_B : ST_PRESENT;
                        end
                    end
                end
            end
            ST_PRESENT: begin
                // The comparator output is valid for the pair currently on
                // op_a/op_b, so sample it on the same edge the pair is taken.
                if (bus.op_ready) begin
                    res_d       = {bus.cmp_gt, bus.cmp_le, bus.cmp_eq};
                    res_valid_d = 1'b1;
                    state_d     = ST_LOAD_A;
                end
            end
            default: begin
                state_d = ST_LOAD_A;
                cnt_d   = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_LOAD_A;
            cnt_q       <= 2'd0;
            op_a_q      <= 16'h0000;
            op_b_q      <= 16'h0000;
            res_valid_q <= 1'b0;
            res_q       <= 3'b001;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            res_valid_q <= res_valid_d;
            res_q       <= res_d;
            err_q       <= err_d;
        end
    end

    assign bus.in_ready  = (state_q != ST_PRESENT);
    assign bus.op_valid  = (state_q == ST_PRESENT);
    assign bus.op_a      = op_a_q;
    assign bus.op_b      = op_b_q;
    assign bus.cas_gt    = CAS_DEFAULT[2];
    assign bus.cas_le    = CAS_DEFAULT[1];
    assign bus.cas_eq    = CAS_DEFAULT[0];
    assign bus.res_valid = res_valid_q;
    assign bus.res_gt    = res_q[2];
    assign bus.res_le    = res_q[1];
    assign bus.res_eq    = res_q[0];
`ifdef CMP16_LOADER_PARITY_EN
    assign bus.err       = err_q;
`else
    // Without parity checking no protocol error can be detected.
    assign bus.err       = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cmp16_operand_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_cmp16_operand_loader
// Description : Self-checking bench for cmp16_operand_loader.
//               - Two loaders, MSB_FIRST=0 and MSB_FIRST=1, see the same
//                 stimulus.
//               - A reference model builds the expected operands from the
//                 nibble stream with shift arithmetic and tracks the expected
//                 result pulse frame by frame.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cmp16_operand_loader;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       in_valid = 1'b0;
    logic [3:0] in_nibble = 4'h0;
    logic       op_ready = 1'b0;
    logic [2:0] cmp_in = 3'b000;      // {gt, le, eq}
    logic       par_bad = 1'b0;

    cmp16_operand_loader_if if0 ();
    cmp16_operand_loader_if if1 ();

    assign if0.in_valid  = in_valid;
    assign if1.in_valid  = in_valid;
    assign if0.in_nibble = in_nibble;
    assign if1.in_nibble = in_nibble;
    assign if0.op_ready  = op_ready;
    assign if1.op_ready  = op_ready;
    assign {if0.cmp_gt, if0.cmp_le, if0.cmp_eq} = cmp_in;
    assign {if1.cmp_gt, if1.cmp_le, if1.cmp_eq} = cmp_in;
`ifdef CMP16_LOADER_PARITY_EN
    assign if0.in_par = par_bad ? (^in_nibble) : ~(^in_nibble);
    assign if1.in_par = par_bad ? (^in_nibble) : ~(^in_nibble);
`endif

    cmp16_operand_loader #(.MSB_FIRST(1'b0), .CAS_DEFAULT(3'b001)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (if0.master)
    );

    cmp16_operand_loader #(.MSB_FIRST(1'b1), .CAS_DEFAULT(3'b001)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1.master)
    );

    int checks = 0;
    int errors = 0;

    // Model state for the result interface and the sticky error flag.
    logic [2:0] exp_res = 3'b001;
    logic       exp_rv  = 1'b0;
    logic       exp_err = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge and check the result interface.
    task automatic tick();
        @(negedge clk);
        chk("res_valid0", 32'(if0.res_valid), 32'(exp_rv));
        chk("res_valid1", 32'(if1.res_valid), 32'(exp_rv));
        chk("res0", 32'({if0.res_gt, if0.res_le, if0.res_eq}), 32'(exp_res));
        chk("res1", 32'({if1.res_gt, if1.res_le, if1.res_eq}), 32'(exp_res));
        chk("err0", 32'(if0.err), 32'(exp_err));
        chk("err1", 32'(if1.err), 32'(exp_err));
        exp_rv = 1'b0;
    endtask

    task automatic chk_load();
        chk("in_ready0_load", 32'(if0.in_ready), 32'd1);
        chk("in_ready1_load", 32'(if1.in_ready), 32'd1);
        chk("op_valid0_load", 32'(if0.op_valid), 32'd0);
        chk("op_valid1_load", 32'(if1.op_valid), 32'd0);
    endtask

    task automatic chk_present(input logic [15:0] a0, input logic [15:0] b0,
                               input logic [15:0] a1, input logic [15:0] b1);
        chk("op_valid0", 32'(if0.op_valid), 32'd1);
        chk("op_valid1", 32'(if1.op_valid), 32'd1);
        chk("in_ready0_pres", 32'(if0.in_ready), 32'd0);
        chk("in_ready1_pres", 32'(if1.in_ready), 32'd0);
        chk("op_a_lsbfirst", 32'(if0.op_a), 32'(a0));
        chk("op_b_lsbfirst", 32'(if0.op_b), 32'(b0));
        chk("op_a_msbfirst", 32'(if1.op_a), 32'(a1));
        chk("op_b_msbfirst", 32'(if1.op_b), 32'(b1));
        chk("cas0", 32'({if0.cas_gt, if0.cas_le, if0.cas_eq}), 32'h1);
        chk("cas1", 32'({if1.cas_gt, if1.cas_le, if1.cas_eq}), 32'h1);
    endtask

    // Drive noise on the inputs that must be ignored in the current state.
    task automatic drive_noise();
        op_ready = 1'($urandom_range(0, 1));
        cmp_in   = 3'($urandom_range(0, 7));
    endtask

    // One frame: stream nibble i is stream[4*i +: 4]; nibbles 0..3 are A.
    task automatic run_frame(input logic [31:0] stream, input logic [2:0] cmp,
                             input int hold, input bit gaps);
        logic [15:0] a0, b0, a1, b1;
        logic [3:0]  s;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        for (int i = 0; i < 4; i++) begin
            s  = stream[4*i +: 4];
            a0 = a0 | (16'(s) << (4 * i));
            a1 = a1 | (16'(s) << (4 * (3 - i)));
            s  = stream[16 + 4*i +: 4];
            b0 = b0 | (16'(s) << (4 * i));
            b1 = b1 | (16'(s) << (4 * (3 - i)));
        end
        for (int i = 0; i < 8; i++) begin
            if (gaps && ($urandom_range(0, 2) == 0)) begin
                tick();
                chk_load();
                in_valid  = 1'b0;
                in_nibble = 4'($urandom);
                drive_noise();
            end
            tick();
            chk_load();
            in_valid  = 1'b1;
            in_nibble = stream[4*i +: 4];
            drive_noise();
        end
        for (int h = 0; h < hold; h++) begin
            tick();
            chk_present(a0, b0, a1, b1);
            in_valid  = 1'($urandom_range(0, 1));
            in_nibble = 4'($urandom);
            op_ready  = 1'b0;
            cmp_in    = 3'($urandom_range(0, 7));
        end
        tick();
        chk_present(a0, b0, a1, b1);
        op_ready  = 1'b1;
        cmp_in    = cmp;
        in_valid  = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
        in_nibble = 4'($urandom);
        exp_rv    = 1'b1;
        exp_res   = cmp;
    endtask

    initial begin
        // Reset state.
        @(posedge clk);
        tick();
        chk_load();
        chk("op_a0_rst", 32'(if0.op_a), 32'd0);
        chk("op_b1_rst", 32'(if1.op_b), 32'd0);
        rst = 1'b0;

        // Directed frames from the nibble stream examples.
        run_frame(32'h2234_1234, 3'b010, 0, 1'b0);
        run_frame(32'h00FF_00FF, 3'b001, 0, 1'b0);

        // Long stall in PRESENT with in_valid toggling.
        run_frame($urandom, 3'($urandom_range(0, 7)), 5, 1'b1);

        // Reset after 5 nibbles, then a clean frame.
        tick();
        chk_load();
        for (int i = 0; i < 5; i++) begin
            in_valid  = 1'b1;
            in_nibble = 4'($urandom);
            drive_noise();
            tick();
            chk_load();
        end
        rst      = 1'b1;
        in_valid = 1'b0;
        exp_res  = 3'b001;
        exp_rv   = 1'b0;
        tick();
        chk_load();
        chk("op_a0_midrst", 32'(if0.op_a), 32'd0);
        chk("op_a1_midrst", 32'(if1.op_a), 32'd0);
        rst = 1'b0;
        run_frame($urandom, 3'($urandom_range(0, 7)), 0, 1'b0);

        // Back-to-back frames: in_valid and op_ready effectively always 1.
        for (int f = 0; f < 4; f++) begin
            run_frame($urandom, 3'($urandom_range(0, 7)), 0, 1'b0);
        end

        // Randomized frames with gaps and variable stalls.
        for (int f = 0; f < 6; f++) begin
            run_frame($urandom, 3'($urandom_range(0, 7)), int'($urandom_range(0, 3)), 1'b1);
        end

`ifdef CMP16_LOADER_PARITY_EN
        // Bad parity on the 6th nibble drops the frame and sets err.
        tick();
        chk_load();
        for (int i = 0; i < 6; i++) begin
            in_valid  = 1'b1;
            in_nibble = 4'($urandom);
            par_bad   = (i == 5);
            drive_noise();
            tick();
            chk_load();
            par_bad   = 1'b0;
        end
        exp_err  = 1'b1;
        in_valid = 1'b0;
        run_frame($urandom, 3'($urandom_range(0, 7)), 1, 1'b0);
`endif

        // Let the final result pulse land and op_valid fall.
        tick();
        op_ready = 1'b0;
        in_valid = 1'b0;
        chk_load();
        tick();
        chk_load();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
